// File: rtl/pwm_motor_pkg.sv
// Shared constants, channel state encoding and BCD helpers for the dual-motor PWM driver.
package pwm_motor_pkg;

  localparam logic [1:0]  DIR_STOP = 2'b00;
  localparam logic [1:0]  DIR_FWD  = 2'b10;
  localparam logic [1:0]  DIR_REV  = 2'b01;
  localparam logic [11:0] BCD_MAX  = 12'h999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } motor_state_t;

  // Three-digit BCD increment; 999 rolls over to 000.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_clamp(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // BCD addition of two valid 3-digit values, saturating at 999.
  function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = 4'(s - 5'd10);
        c           = 1'b1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c           = 1'b0;
      end
    end
    return c ? BCD_MAX : r;
  endfunction

endpackage

// File: rtl/pwm_driver_motoare_if.sv
// Bundle of direction/duty requests and bridge outputs between movement logic and the PWM driver.
interface pwm_driver_motoare_if;
  logic [1:0]  directie_driverA;
  logic [1:0]  directie_driverB;
  logic [11:0] factor_dc_driverA;
  logic [11:0] factor_dc_driverB;
  logic        in1_A;
  logic        in2_A;
  logic        in1_B;
  logic        in2_B;
  logic        pwm_A;
  logic        pwm_B;
  logic        period_start;

  modport master (
    output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
    input  in1_A, in2_A, in1_B, in2_B, pwm_A, pwm_B, period_start
  );

  modport slave (
    input  directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
    output in1_A, in2_A, in1_B, in2_B, pwm_A, pwm_B, period_start
  );
endinterface

// File: rtl/canal_motor.sv
// One motor channel: direction synchroniser, IDLE/FWD/REV/DEAD FSM, duty latch and PWM compare.
// Macro SOFT_START_EN adds a per-period BCD duty ramp after every entry into a run state.
module canal_motor
  import pwm_motor_pkg::*;
#(
  parameter int          DEAD_PER  = 20,
  parameter logic [11:0] RAMP_STEP = 12'h050
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  directie,
  input  logic [11:0] factor_dc,
  input  logic [11:0] cnt,
  input  logic        wrap,
  output logic        in1,
  output logic        in2,
  output logic        pwm
);

  localparam int DW = (DEAD_PER < 2) ? 1 : $clog2(DEAD_PER + 1);

  logic [1:0]   dir_s1_reg, dir_s2_reg;
  motor_state_t state_reg, state_next;
  motor_state_t target_reg, target_next;
  logic [DW-1:0] dead_reg, dead_next;
  logic [11:0]  duty_lat_reg, duty_lat_next;
  logic [11:0]  duty_eff;
  logic         req_fwd, req_rev, run_now, run_next;

  assign req_fwd       = (dir_s2_reg == DIR_FWD);
  assign req_rev       = (dir_s2_reg == DIR_REV);
  assign duty_lat_next = wrap ? bcd_clamp(factor_dc) : duty_lat_reg;
  assign run_now       = (state_reg == ST_FWD) || (state_reg == ST_REV);
  assign run_next      = (state_next == ST_FWD) || (state_next == ST_REV);

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_s1_reg   <= DIR_STOP;
      dir_s2_reg   <= DIR_STOP;
      state_reg    <= ST_IDLE;
      target_reg   <= ST_IDLE;
      dead_reg     <= '0;
      duty_lat_reg <= '0;
    end else begin
      dir_s1_reg   <= directie;
      dir_s2_reg   <= dir_s1_reg;
      state_reg    <= state_next;
      target_reg   <= target_next;
      dead_reg     <= dead_next;
      duty_lat_reg <= duty_lat_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    dead_next   = dead_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_fwd)      state_next = ST_FWD;
        else if (req_rev) state_next = ST_REV;
      end
      ST_FWD: begin
        if (req_rev) begin
          state_next  = ST_DEAD;
          target_next = ST_REV;
          dead_next   = DW'(DEAD_PER);
        end else if (!req_fwd) begin
          state_next = ST_IDLE;
        end
      end
      ST_REV: begin
        if (req_fwd) begin
          state_next  = ST_DEAD;
          target_next = ST_FWD;
          dead_next   = DW'(DEAD_PER);
        end else if (!req_rev) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        // A retarget inside the dead time keeps the running count.
        if (!req_fwd && !req_rev) begin
          state_next = ST_IDLE;
        end else begin
          target_next = req_fwd ? ST_FWD : ST_REV;
          if (wrap) begin
            if (dead_reg == '0) state_next = target_next;
            else                dead_next  = dead_reg - DW'(1);
          end
        end
      end
    endcase
  end

`ifdef SOFT_START_EN
  logic [11:0] eff_reg;
  logic [11:0] ramp_sum;

  assign ramp_sum = bcd_add_sat(eff_reg, RAMP_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      eff_reg <= '0;
    end else if (run_next && !run_now) begin
      eff_reg <= '0;
    end else if (wrap) begin
      eff_reg <= (ramp_sum < duty_lat_next) ? ramp_sum : duty_lat_next;
    end
  end

  assign duty_eff = eff_reg;
`else
  logic unused_ramp;
  assign unused_ramp = ^RAMP_STEP;
  assign duty_eff    = duty_lat_reg;
`endif

  assign in1 = (state_reg == ST_FWD);
  assign in2 = (state_reg == ST_REV);
  assign pwm = run_now && (cnt < duty_eff);

endmodule

// File: rtl/pwm_driver_motoare.sv
// Dual H-bridge PWM driver: shared prescaler and BCD 000..999 period counter feeding two motor channels.
// Macro SOFT_START_EN enables the duty ramp inside each channel.
module pwm_driver_motoare
  import pwm_motor_pkg::*;
#(
  parameter int          PRESC_DIV = 50,
  parameter int          DEAD_PER  = 20,
  parameter logic [11:0] RAMP_STEP = 12'h050
) (
  input  logic             clk,
  input  logic             rst,
  pwm_driver_motoare_if.slave bus
);

  localparam int PW = (PRESC_DIV < 2) ? 1 : $clog2(PRESC_DIV);

  logic [PW-1:0] presc_reg;
  logic [11:0]   cnt_reg;
  logic          period_start_reg;
  logic          tick, wrap;

  logic [1:0]  dir_arr  [2];
  logic [11:0] duty_arr [2];
  logic [1:0]  in1_vec, in2_vec, pwm_vec;

  assign tick = (presc_reg == PW'(PRESC_DIV - 1));
  assign wrap = tick && (cnt_reg == BCD_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg        <= '0;
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      presc_reg        <= tick ? '0 : presc_reg + PW'(1);
      if (tick) cnt_reg <= bcd_inc(cnt_reg);
      period_start_reg <= wrap;
    end
  end

  assign dir_arr[0]  = bus.directie_driverA;
  assign dir_arr[1]  = bus.directie_driverB;
  assign duty_arr[0] = bus.factor_dc_driverA;
  assign duty_arr[1] = bus.factor_dc_driverB;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_canal
      canal_motor #(
        .DEAD_PER  (DEAD_PER),
        .RAMP_STEP (RAMP_STEP)
      ) u_canal (
        .clk       (clk),
        .rst       (rst),
        .directie  (dir_arr[gi]),
        .factor_dc (duty_arr[gi]),
        .cnt       (cnt_reg),
        .wrap      (wrap),
        .in1       (in1_vec[gi]),
        .in2       (in2_vec[gi]),
        .pwm       (pwm_vec[gi])
      );
    end
  endgenerate

  assign bus.in1_A        = in1_vec[0];
  assign bus.in2_A        = in2_vec[0];
  assign bus.pwm_A        = pwm_vec[0];
  assign bus.in1_B        = in1_vec[1];
  assign bus.in2_B        = in2_vec[1];
  assign bus.pwm_B        = pwm_vec[1];
  assign bus.period_start = period_start_reg;

endmodule
